barycentric_shader: RTL
=======================

# barycentric_shader

Downstream consumer of the interpolation-weight stage in the rasterizer pixel pipeline. On each new set of barycentric weights it rejects pixels outside the triangle. For pixels inside, it computes interpolated RGB colour and depth from the three vertex attributes using one time-shared multiplier. The shaded pixel is presented to the framebuffer writer over a valid/ready handshake.

## Interface
- FRAC_BITS, 16, fractional bits of weights (signed Q15.16 in 32 bits)
- CNT_W, 8, width of saturating diagnostic counters
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- interp_done  in  1  level from weight stage; rising edge marks new w0..w2
- w0, w1, w2  in  32  signed Q15.16 barycentric weights
- c0, c1, c2  in  24  vertex colours {R,G,B}, 8-bit unsigned each
- z0, z1, z2  in  16  vertex depths, unsigned
- pix_x, pix_y  in  10  pixel coordinates, sampled with weights
- out_valid  out  1  shaded pixel available
- out_ready  in  1  downstream accepts pixel
- out_rgb  out  24  interpolated colour
- out_z  out  16  interpolated depth
- out_x, out_y  out  10  pixel coordinates
- busy  out  1  high in any state except IDLE
- reject_cnt  out  CNT_W  outside-triangle pixels, saturating
- drop_cnt  out  CNT_W  events ignored while busy, saturating

## Operation
- Event: interp_done==1 with registered previous value 0. A held-high level produces exactly one event.
- States: IDLE, CHECK, MAC, ROUND, OUT.
- IDLE, on event: latch w0..w2, c0..c2, z0..z2, pix_x, pix_y into internal registers. Go to CHECK.
- CHECK:
  - If any latched weight has bit 31 set, the pixel is outside. Increment reject_cnt and return to IDLE.
  - Otherwise clear the accumulator, set idx=0 and go to MAC.
- MAC: 12 cycles. idx 0..11 selects attribute a = idx/3 (R, G, B, Z) and weight k = idx%3.
  - Each cycle: acc += w_k × zero-extended attribute_k(a).
  - The signed product is 49 bits wide.
  - The accumulator is at least 51 bits, signed.
  - At k==2 the accumulator is stored to result slot a and cleared.
- ROUND: for each slot, r = (slot + 2^(FRAC_BITS-1)) >>> FRAC_BITS.
  - Saturate r to [0,255] for colour or [0,65535] for depth.
  - Register the results to out_rgb and out_z, copy coordinates to out_x and out_y.
  - Set out_valid=1 and go to OUT.
- OUT: hold all outputs stable. When out_ready==1, clear out_valid and return to IDLE.
- An event seen in any state other than IDLE is discarded and increments drop_cnt. This includes the OUT cycle in which the handshake completes.
- Counters stick at 2^CNT_W−1.
- No check is made that the weights sum to 1.0. Oversized weights are handled only by saturation.

## Timing
- Event sampled at edge N.
- CHECK is executed at edge N+1.
- MAC occupies edges N+2..N+13.
- ROUND at edge N+14; out_valid is high after edge N+14.
- Minimum event-to-out_valid latency: 15 cycles.
- Handshake completes at the first edge with out_valid & out_ready. out_valid is low after that edge.
- Throughput: at most one pixel per 16 cycles with out_ready held high.
- Reset values:
  - out_valid=0, busy=0, reject_cnt=0, drop_cnt=0.
  - out_rgb=0, out_z=0, out_x=0, out_y=0.
  - State IDLE, accumulator and slots 0.
  - Previous-interp_done register=0, so interp_done high on the first cycle out of reset is an event.
- Reset in any state, including mid-MAC and OUT, aborts the operation. There is no partial output.
- Input buses are only sampled at the event edge. Changes afterwards do not affect the result.

## Test plan
- Corner weight: w0=0x00010000, w1=w2=0, c0=0x102030, z0=0x1234 -> out_rgb=0x102030 and out_z=0x1234, with out_valid high exactly 15 cycles after the event.
- Equal thirds: w0=w1=w2=0x00005555, c0=0xFF0000, c1=0x00FF00, c2=0x0000FF, z0=z1=z2=0x0300 -> out_rgb=0x555555, out_z=0x0300.
- Outside: w1=0xFFFF0000 -> out_valid never rises, reject_cnt=1, busy low again after 2 cycles.
- Backpressure and drop: hold out_ready=0 for 5 cycles after out_valid and pulse interp_done during the hold -> outputs stable, drop_cnt=1, exactly one pixel accepted.
- Saturation: w0=0x00020000, c0=0xFF80FF, z0=0xFFFF -> out_rgb=0xFFFFFF, out_z=0xFFFF.
- Reset mid-MAC and held level: assert rst at event+6, then hold interp_done high for 40 cycles -> no output before the reset, exactly one pixel afterwards, counters 0.

Source files
------------

// File: rtl/barycentric_shader_if.sv
// Shaded-pixel handshake from the barycentric shader to the framebuffer writer.
// The producer drives pixel data and valid; the consumer drives ready.
interface barycentric_shader_if;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_rgb;
  logic [15:0] out_z;
  logic [9:0]  out_x;
  logic [9:0]  out_y;

  modport master (
    output out_valid,
    output out_rgb,
    output out_z,
    output out_x,
    output out_y,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_rgb,
    input  out_z,
    input  out_x,
    input  out_y,
    output out_ready
  );
endinterface

// File: rtl/barycentric_shader.sv
// Rejects pixels outside the triangle, then interpolates RGB and depth from the
// three vertex attributes with one time-shared multiplier and offers the result.
module barycentric_shader #(
  parameter int FRAC_BITS = 16,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 interp_done,
  input  logic [31:0]          w0,
  input  logic [31:0]          w1,
  input  logic [31:0]          w2,
  input  logic [23:0]          c0,
  input  logic [23:0]          c1,
  input  logic [23:0]          c2,
  input  logic [15:0]          z0,
  input  logic [15:0]          z1,
  input  logic [15:0]          z2,
  input  logic [9:0]           pix_x,
  input  logic [9:0]           pix_y,
  barycentric_shader_if.master out_if,
  output logic                 busy,
  output logic [CNT_W-1:0]     reject_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int ACC_W = 51;
  localparam logic signed [ACC_W-1:0] HALF = 51'sd1 <<< (FRAC_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MAC,
    S_ROUND,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic                    done_q;
  logic                    ev;
  logic signed [31:0]      w_q [3];
  logic [23:0]             c_q [3];
  logic [15:0]             z_q [3];
  logic [9:0]              x_q, y_q;
  logic [1:0]              a_q, k_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] slot_q [4];
  logic [23:0]             rgb_q;
  logic [15:0]             zo_q;
  logic [9:0]              ox_q, oy_q;
  logic [CNT_W-1:0]        reject_q, drop_q;

  logic                    outside;
  logic                    mac_last;
  logic signed [31:0]      w_sel;
  logic [23:0]             c_sel;
  logic [15:0]             z_sel;
  logic [15:0]             attr;
  logic signed [48:0]      mul_w, mul_a, prod;
  logic signed [ACC_W-1:0] prod_ext, acc_sum;
  logic signed [ACC_W-1:0] rnd [4];
  logic signed [ACC_W-1:0] rsum;

  function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] r);
    if (r < 0)              return '0;
    else if (r > 51'sd255)  return '1;
    else                    return r[7:0];
  endfunction

  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] r);
    if (r < 0)               return '0;
    else if (r > 51'sd65535) return '1;
    else                     return r[15:0];
  endfunction

  assign ev       = interp_done & ~done_q;
  assign outside  = w_q[0][31] | w_q[1][31] | w_q[2][31];
  assign mac_last = (a_q == 2'd3) && (k_q == 2'd2);

  // Operand select: k picks the vertex, a picks the channel (R, G, B, Z).
  always_comb begin
    case (k_q)
      2'd0:    begin w_sel = w_q[0]; c_sel = c_q[0]; z_sel = z_q[0]; end
      2'd1:    begin w_sel = w_q[1]; c_sel = c_q[1]; z_sel = z_q[1]; end
      default: begin w_sel = w_q[2]; c_sel = c_q[2]; z_sel = z_q[2]; end
    endcase
    case (a_q)
      2'd0:    attr = {8'h00, c_sel[23:16]};
      2'd1:    attr = {8'h00, c_sel[15:8]};
      2'd2:    attr = {8'h00, c_sel[7:0]};
      default: attr = z_sel;
    endcase
    mul_w    = {{17{w_sel[31]}}, w_sel};
    mul_a    = {33'd0, attr};
    prod     = mul_w * mul_a;
    prod_ext = {{2{prod[48]}}, prod};
    acc_sum  = acc_q + prod_ext;
  end

  always_comb begin
    rsum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rsum   = slot_q[i] + HALF;
      rnd[i] = rsum >>> FRAC_BITS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ev) state_d = S_CHECK;
      S_CHECK: state_d = outside ? S_IDLE : S_MAC;
      S_MAC:   if (mac_last) state_d = S_ROUND;
      S_ROUND: state_d = S_OUT;
      S_OUT:   if (out_if.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q != S_IDLE);
    out_if.out_valid = (state_q == S_OUT);
    out_if.out_rgb   = rgb_q;
    out_if.out_z     = zo_q;
    out_if.out_x     = ox_q;
    out_if.out_y     = oy_q;
    reject_cnt       = reject_q;
    drop_cnt         = drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      a_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      rgb_q    <= '0;
      zo_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      reject_q <= '0;
      drop_q   <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        w_q[i] <= '0;
        c_q[i] <= '0;
        z_q[i] <= '0;
      end
      for (int unsigned i = 0; i < 4; i++) slot_q[i] <= '0;
    end else begin
      done_q <= interp_done;
      if (ev && state_q != S_IDLE && drop_q != '1)
        drop_q <= drop_q + CNT_W'(1);
      case (state_q)
        S_IDLE: begin
          if (ev) begin
            w_q[0] <= w0;  w_q[1] <= w1;  w_q[2] <= w2;
            c_q[0] <= c0;  c_q[1] <= c1;  c_q[2] <= c2;
            z_q[0] <= z0;  z_q[1] <= z1;  z_q[2] <= z2;
            x_q    <= pix_x;
            y_q    <= pix_y;
          end
        end
        S_CHECK: begin
          if (outside) begin
            if (reject_q != '1) reject_q <= reject_q + CNT_W'(1);
          end else begin
            acc_q <= '0;
            a_q   <= '0;
            k_q   <= '0;
          end
        end
        S_MAC: begin
          // The third product of each channel goes straight into its slot.
          if (k_q == 2'd2) begin
            slot_q[a_q] <= acc_sum;
            acc_q       <= '0;
            k_q         <= '0;
            a_q         <= a_q + 2'd1;
          end else begin
            acc_q <= acc_sum;
            k_q   <= k_q + 2'd1;
          end
        end
        S_ROUND: begin
          rgb_q <= {sat8(rnd[0]), sat8(rnd[1]), sat8(rnd[2])};
          zo_q  <= sat16(rnd[3]);
          ox_q  <= x_q;
          oy_q  <= y_q;
        end
        default: ;
      endcase
    end
  end

endmodule
